// File: rtl/divisor_secuencial_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master side requests a division; the slave side is the divider itself.
interface divisor_secuencial_if #(
  parameter int ANCHO = 3
);
  logic                   inicio;
  logic [ANCHO-1:0]       entrada_d;
  logic [ANCHO-1:0]       entrada_m;
  logic                   ocupado;
  logic                   fin;
  logic                   div_cero;
  logic [2*ANCHO-1:0]     resultado;

  modport master (
    output inicio, entrada_d, entrada_m,
    input  ocupado, fin, div_cero, resultado
  );

  modport slave (
    input  inicio, entrada_d, entrada_m,
    output ocupado, fin, div_cero, resultado
  );
endinterface

// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider with A/Q/M registers and one shared
// subtractor. One shift cycle plus one subtract/restore cycle per quotient bit.
//
// state | meaning
// IDLE  | waiting for inicio, operands captured when it is seen
// LOAD  | A cleared, Q/M loaded from the captured operands, counter cleared
// DESP  | {A,Q} shifted left by one, Q[0] cleared
// RESTA | trial subtract A-M; keep difference and set Q[0] if non-negative
// FIN   | result valid and held; inicio starts a new division
module divisor_secuencial #(
  parameter int ANCHO = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  divisor_secuencial_if.slave  bus
);

  localparam int CW = $clog2(ANCHO + 1);
  localparam logic [CW-1:0] CNT_FIN = CW'(ANCHO);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DESP  = 3'd2,
    RESTA = 3'd3,
    FIN   = 3'd4
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [ANCHO:0]   a_q, a_d;
  logic [ANCHO-1:0] q_q, q_d;
  logic [ANCHO-1:0] m_q, m_d;
  logic [ANCHO-1:0] d_cap_q, d_cap_d;
  logic [ANCHO-1:0] m_cap_q, m_cap_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // After a shift A may reach 2*M-1, so the sign needs one bit beyond A.
  logic [ANCHO+1:0] dif;
  logic             signo;

  assign dif   = {1'b0, a_q} - {2'b00, m_q};
  assign signo = dif[ANCHO+1];

  // Next-state and datapath update; operands are captured only when inicio is accepted.
  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    d_cap_d  = d_cap_q;
    m_cap_d  = m_cap_q;
    cnt_d    = cnt_q;
    case (estado_q)
      IDLE, FIN: begin
        if (bus.inicio) begin
          estado_d = LOAD;
          d_cap_d  = bus.entrada_d;
          m_cap_d  = bus.entrada_m;
        end
      end
      LOAD: begin
        a_d      = '0;
        q_d      = d_cap_q;
        m_d      = m_cap_q;
        cnt_d    = '0;
        estado_d = DESP;
      end
      DESP: begin
        {a_d, q_d} = {a_q[ANCHO-1:0], q_q, 1'b0};
        estado_d   = RESTA;
      end
      RESTA: begin
        if (!signo) begin
          a_d    = dif[ANCHO:0];
          q_d[0] = 1'b1;
        end else begin
          q_d[0] = 1'b0;
        end
        cnt_d    = cnt_q + 1'b1;
        estado_d = (cnt_d == CNT_FIN) ? FIN : DESP;
      end
      default: estado_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      d_cap_q  <= '0;
      m_cap_q  <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      d_cap_q  <= d_cap_d;
      m_cap_q  <= m_cap_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ocupado   = (estado_q == LOAD) || (estado_q == DESP) || (estado_q == RESTA);
  assign bus.fin       = (estado_q == FIN);
  assign bus.div_cero  = (estado_q == FIN) && (m_q == '0);
  assign bus.resultado = {a_q[ANCHO-1:0], q_q};

endmodule
